// File: rtl/mux_pkg.sv
// Shared types and select encodings for the 16-bit four-input operand selector.
package mux_pkg;
  localparam int DATA_W = 16;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mux_16bit_4i_1o_if.sv
// Operand/select bus of the selector: the master drives operands, the slave returns results.
interface mux_16bit_4i_1o_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) ();
  logic [1:0]       s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] r;
  logic [3:0]       sel_oh;
  logic [WIDTH-1:0] r_q;
  logic [1:0]       s_q;

  modport master (output s, a, b, c, d, en, input r, sel_oh, r_q, s_q);
  modport slave  (input s, a, b, c, d, en, output r, sel_oh, r_q, s_q);
endinterface

// File: rtl/mux4_core.sv
// Pure combinational 4:1 operand select with a one-hot decode of the select.
module mux4_core
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       sel_oh
);
  // Defaults double as the SEL_A branch, so a non-binary select resolves to a.
  always_comb begin
    r      = a;
    sel_oh = 4'b0001;
    case (s)
      SEL_B: begin
        r      = b;
        sel_oh = 4'b0010;
      end
      SEL_C: begin
        r      = c;
        sel_oh = 4'b0100;
      end
      SEL_D: begin
        r      = d;
        sel_oh = 4'b1000;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mux_16bit_4i_1o.sv
// Operand selector top: combinational select plus an enable-gated capture of result and select.
module mux_16bit_4i_1o
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic               clk,
  input logic               reset,
  mux_16bit_4i_1o_if.slave  bus
);
  logic [WIDTH-1:0] r_sel;
  logic [3:0]       oh;

  mux4_core #(.WIDTH(WIDTH)) u_core (
    .s      (bus.s),
    .a      (bus.a),
    .b      (bus.b),
    .c      (bus.c),
    .d      (bus.d),
    .r      (r_sel),
    .sel_oh (oh)
  );

  assign bus.r      = r_sel;
  assign bus.sel_oh = oh;

  // Reset beats enable; result and select are captured on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.r_q <= '0;
      bus.s_q <= '0;
    end else if (bus.en) begin
      bus.r_q <= r_sel;
      bus.s_q <= bus.s;
    end
  end
endmodule

// File: tb/tb_mux_16bit_4i_1o.sv
// Directed self-checking bench for the 16-bit four-input operand selector.
module tb_mux_16bit_4i_1o;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mux_16bit_4i_1o_if bus ();

  mux_16bit_4i_1o dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] va, vb, vc, vd, ve;
    logic [15:0] r_hold;
    logic [3:0]  oh_hold;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.en = 1'b0;
    bus.s  = 2'd0;
    bus.a  = 16'h0;
    bus.b  = 16'h0;
    bus.c  = 16'h0;
    bus.d  = 16'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_r_q", 32'(bus.r_q), 32'h0);
    chk("reset_s_q", 32'(bus.s_q), 32'h0);
    reset = 1'b0;

    // Sweep: each operand takes a distinct pair of multiples of 8.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 16; i++) begin
        va = 16'((i & 1) * 8);
        vb = 16'(((i >> 1) & 1) * 8 + 16);
        vc = 16'(((i >> 2) & 1) * 8 + 32);
        vd = 16'(((i >> 3) & 1) * 8 + 48);
        bus.s = 2'(s);
        bus.a = va;
        bus.b = vb;
        bus.c = vc;
        bus.d = vd;
        #10;
        case (s)
          0: ve = va;
          1: ve = vb;
          2: ve = vc;
          default: ve = vd;
        endcase
        chk("sweep_r", 32'(bus.r), 32'(ve));
        chk("sweep_sel_oh", 32'(bus.sel_oh), 32'(4'b0001 << s));
      end
    end

    // Isolation of unselected operands.
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.c = 16'h3333;
    bus.d = 16'h4444;
    bus.s = 2'd2;
    #10;
    chk("iso_r", 32'(bus.r), 32'h3333);
    chk("iso_sel_oh", 32'(bus.sel_oh), 32'h4);
    bus.a = 16'hFFFF;
    #1;
    chk("iso_unsel_change", 32'(bus.r), 32'h3333);
    bus.c = 16'h0000;
    #1;
    chk("iso_sel_change", 32'(bus.r), 32'h0000);

    // Full-width pass-through.
    bus.d = 16'hFFFF;
    bus.s = 2'd3;
    #1;
    chk("full_d", 32'(bus.r), 32'hFFFF);
    chk("full_d_oh", 32'(bus.sel_oh), 32'h8);
    bus.a = 16'h8001;
    bus.s = 2'd0;
    #1;
    chk("full_a", 32'(bus.r), 32'h8001);

    // Register capture on a single enabled edge.
    @(negedge clk);
    chk("pre_cap_r_q", 32'(bus.r_q), 32'h0);
    bus.s  = 2'd1;
    bus.b  = 16'h00A5;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    chk("cap_r_q", 32'(bus.r_q), 32'h00A5);
    chk("cap_s_q", 32'(bus.s_q), 32'h1);
    bus.b = 16'h5A00;
    #1;
    chk("cap_r_live", 32'(bus.r), 32'h5A00);
    @(negedge clk);
    chk("hold_r_q", 32'(bus.r_q), 32'h00A5);
    chk("hold_s_q", 32'(bus.s_q), 32'h1);

    // Synchronous reset wins over enable, only at the edge.
    reset  = 1'b1;
    bus.en = 1'b1;
    #1;
    chk("rst_before_edge_r_q", 32'(bus.r_q), 32'h00A5);
    chk("rst_before_edge_s_q", 32'(bus.s_q), 32'h1);
    chk("rst_r_tracks", 32'(bus.r), 32'h5A00);
    @(negedge clk);
    chk("rst_r_q", 32'(bus.r_q), 32'h0);
    chk("rst_s_q", 32'(bus.s_q), 32'h0);
    chk("rst_r_live", 32'(bus.r), 32'h5A00);
    bus.b = 16'h1234;
    #1;
    chk("rst_r_follow", 32'(bus.r), 32'h1234);
    reset  = 1'b0;
    bus.en = 1'b0;

    // Clock and reset activity must not disturb the combinational outputs.
    bus.s = 2'd2;
    bus.c = 16'hC3C3;
    #1;
    r_hold  = 16'hC3C3;
    oh_hold = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      reset = k[0];
      #3;
      chk("indep_r", 32'(bus.r), 32'(r_hold));
      chk("indep_sel_oh", 32'(bus.sel_oh), 32'(oh_hold));
    end
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_16bit_4i_1o.md
Name: mux_16bit_4i_1o

Overview:
- Datapath selector: routes one of four 16-bit operands (a, b, c, d) to output r under a 2-bit select s.
- Feeds ALU/register-file operand paths in the 16-bit accumulator processor.
- The primary output r is purely combinational.
- A clocked, enable-gated capture register (r_q) and a one-hot select decode are provided for pipelined consumers.

Parameters:
- WIDTH, 16, data width of a, b, c, d, r, r_q.

Ports:
- clk  in  1  rising-edge clock; used only by the capture register.
- reset  in  1  synchronous, active-high; clears the registered outputs only.
- s  in  2  select: 0 picks a, 1 picks b, 2 picks c, 3 picks d.
- a  in  WIDTH  operand 0.
- b  in  WIDTH  operand 1.
- c  in  WIDTH  operand 2.
- d  in  WIDTH  operand 3.
- en  in  1  capture enable for r_q and s_q.
- r  out  WIDTH  combinational selected operand.
- sel_oh  out  4  combinational one-hot decode of s; bit i is high when s==i.
- r_q  out  WIDTH  registered copy of r.
- s_q  out  2  select value captured alongside r_q.

Behaviour:
- r, combinational, zero cycles:
  - s==0: r=a; s==1: r=b; s==2: r=c; s==3: r=d.
  - r is valid within one delta of any input change.
  - r is never affected by clk, reset or en.
- Any change on the selected operand propagates to r immediately.
- Changes on unselected operands leave r unchanged.
- s non-binary (X/Z) in simulation: r=a and sel_oh=4'b0001. This is the default branch; no latch is inferred.
- sel_oh: exactly one bit high for every legal s. sel_oh is {s==3, s==2, s==1, s==0}.
- Registered path, at each rising clk:
  - reset=1: r_q<=0, s_q<=0. Reset takes priority over en.
  - else en=1: r_q<=r and s_q<=s, both sampled in the same cycle.
  - else: r_q and s_q hold.
- Reset value of every output:
  - r_q=0, s_q=0.
  - r and sel_oh follow their inputs during reset.
- Latency: r is 0 cycles; r_q and s_q are 1 cycle after an en-qualified edge.
- Reset asserted mid-operation: r_q and s_q clear on that edge; r continues tracking the inputs.
- Width rule: no arithmetic and no truncation; the full WIDTH bits are passed through unmodified, including all-ones values.

Decomposition:
- Shared package (mux_pkg) holds:
  - localparam DATA_W=16.
  - Select encodings SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2, SEL_D=2'd3.
  - typedef data_t = logic [DATA_W-1:0].
- Sub-module mux4_core: the pure combinational 4:1 selection, with the sel_oh decode.
- The top level adds the reset/enable capture register around mux4_core.

Test Plan:
- Exhaustive sweep:
  - s steps 0..3; a, b, c, d each take values in {0, 8, 16, 24, ...}, incremented by 8 in nested loops, 16 combinations per s.
  - Inputs are held 10 ns before each check.
  - Required: r equals a/b/c/d for s=0/1/2/3 in every one of the 64 checks.
- Isolation: a=16'h1111, b=16'h2222, c=16'h3333, d=16'h4444.
  - s=2 -> r=16'h3333, sel_oh=4'b0100.
  - Change a to 16'hFFFF -> r stays 16'h3333.
  - Change c to 16'h0000 -> r=16'h0000 at once.
- Full-width pass-through: d=16'hFFFF, s=3 -> r=16'hFFFF; a=16'h8001, s=0 -> r=16'h8001.
- Register capture: s=1, b=16'h00A5.
  - en=1 for one edge -> r_q=16'h00A5, s_q=1 after that edge.
  - Then en=0, b=16'h5A00 -> r=16'h5A00 while r_q holds 16'h00A5.
- Synchronous reset: with r_q=16'h00A5, assert reset=1 together with en=1 at an edge -> r_q=0 and s_q=0 at that edge, not before it. r keeps tracking the inputs throughout.
- Combinational independence: toggle clk and reset with no input changes -> r and sel_oh never glitch or change.
